// File: rtl/uart_receiver_if.sv
// Byte-side handshake between the UART receiver (master) and its consumer (slave).
interface uart_receiver_if;
   logic [7:0] data;
   logic       data_ready;
   logic       data_ack;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      output data, data_ready, frame_err, overrun, busy,
      input  data_ack
   );

   modport slave (
      input  data, data_ready, frame_err, overrun, busy,
      output data_ack
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises RxD, centre-samples start/data/stop bits and
// holds each byte until the consumer acknowledges it.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int SYNC_STAGES  = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RxD,
   uart_receiver_if.master rx
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_reg, state_next;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic [CW-1:0]          baud_reg, baud_next;
   logic [2:0]             bit_reg, bit_next;
   logic [7:0]             shift_reg, shift_next;
   logic [7:0]             data_reg, data_next;
   logic                   ready_reg, ready_next;
   logic                   ferr_reg, ferr_next;
   logic                   overrun_reg, overrun_next;
   logic                   rx_s;

   assign rx_s = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         sync_reg    <= '1;
         baud_reg    <= '0;
         bit_reg     <= '0;
         shift_reg   <= '0;
         data_reg    <= '0;
         ready_reg   <= 1'b0;
         ferr_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         sync_reg    <= {sync_reg[SYNC_STAGES-2:0], RxD};
         baud_reg    <= baud_next;
         bit_reg     <= bit_next;
         shift_reg   <= shift_next;
         data_reg    <= data_next;
         ready_reg   <= ready_next;
         ferr_reg    <= ferr_next;
         overrun_reg <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      baud_next    = baud_reg + CW'(1);
      bit_next     = bit_reg;
      shift_next   = shift_reg;
      data_next    = data_reg;
      // An ack clears the flag unless a completing byte reloads it below.
      ready_next   = ready_reg & ~rx.data_ack;
      ferr_next    = 1'b0;
      overrun_next = overrun_reg;

      unique case (state_reg)
         IDLE: begin
            baud_next = '0;
            if (!rx_s) state_next = START;
         end
         START: begin
            if (baud_reg == HALF_CNT) begin
               if (rx_s) begin
                  state_next = IDLE;
               end else begin
                  state_next = DATA;
                  baud_next  = '0;
                  bit_next   = '0;
               end
            end
         end
         DATA: begin
            if (baud_reg == LAST_CNT) begin
               shift_next = {rx_s, shift_reg[7:1]};
               baud_next  = '0;
               if (bit_reg == 3'd7) state_next = STOP;
               else                 bit_next   = bit_reg + 3'd1;
            end
         end
         STOP: begin
            if (baud_reg == LAST_CNT) begin
               state_next = IDLE;
               baud_next  = '0;
               if (rx_s) begin
                  data_next  = shift_reg;
                  ready_next = 1'b1;
                  if (ready_reg && !rx.data_ack) overrun_next = 1'b1;
               end else begin
                  ferr_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign rx.data       = data_reg;
   assign rx.data_ready = ready_reg;
   assign rx.frame_err  = ferr_reg;
   assign rx.overrun    = overrun_reg;
   assign rx.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clk/bit: a vector table of frames plus
// hand-written sequences for glitch, back-to-back, reset-abort and ack/load races.
module tb_uart_receiver;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic RxD = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   ferr_cnt = 0;
   int   busy_cnt = 0;

   uart_receiver_if ifc ();

   uart_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .RxD   (RxD),
      .rx    (ifc.master)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ifc.frame_err === 1'b1) ferr_cnt++;
      if (ifc.busy === 1'b1)      busy_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] tx;
      logic       stop;
      logic       ack;
      logic [7:0] exp_data;
      logic       exp_ready;
      int         exp_ferr;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one 8N1 frame, LSB first; called and returns on a falling edge.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      RxD = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         idle(CPB);
      end
      RxD = stop;
      idle(CPB);
      RxD = 1'b1;
   endtask

   task automatic consume(input logic [7:0] exp, input string name);
      int n = 0;
      while (ifc.data_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({name, " ready_seen"}, 32'(n < 400), 32'd1);
      check({name, " data"}, 32'(ifc.data), 32'(exp));
      ifc.data_ack = 1'b1;
      @(negedge clk);
      ifc.data_ack = 1'b0;
      check({name, " ready_cleared"}, 32'(ifc.data_ready), 32'd0);
   endtask

   initial begin
      int f0;
      int b0;
      vecs[0] = '{tx:8'hA5, stop:1'b1, ack:1'b0, exp_data:8'hA5, exp_ready:1'b1, exp_ferr:0, exp_ovr:1'b0};
      vecs[1] = '{tx:8'h55, stop:1'b0, ack:1'b1, exp_data:8'hA5, exp_ready:1'b1, exp_ferr:1, exp_ovr:1'b0};
      vecs[2] = '{tx:8'h3C, stop:1'b1, ack:1'b0, exp_data:8'h3C, exp_ready:1'b1, exp_ferr:0, exp_ovr:1'b0};
      vecs[3] = '{tx:8'hC3, stop:1'b1, ack:1'b1, exp_data:8'hC3, exp_ready:1'b1, exp_ferr:0, exp_ovr:1'b1};

      ifc.data_ack = 1'b0;
      idle(4);
      check("reset data",       32'(ifc.data),       32'h00);
      check("reset data_ready", 32'(ifc.data_ready), 32'd0);
      check("reset frame_err",  32'(ifc.frame_err),  32'd0);
      check("reset overrun",    32'(ifc.overrun),    32'd0);
      check("reset busy",       32'(ifc.busy),       32'd0);
      reset = 1'b0;
      idle(4);

      // Ack with nothing pending has no effect
      ifc.data_ack = 1'b1;
      idle(1);
      ifc.data_ack = 1'b0;
      idle(2);
      check("stray ack ready", 32'(ifc.data_ready), 32'd0);

      // 4-cycle glitch: START lasts exactly (CPB-1)/2+1 cycles then aborts
      b0 = busy_cnt;
      RxD = 1'b0;
      idle(4);
      RxD = 1'b1;
      idle(3 * CPB);
      check("glitch busy cycles", 32'(busy_cnt - b0), 32'd8);
      check("glitch ready",       32'(ifc.data_ready), 32'd0);
      check("glitch busy end",    32'(ifc.busy),       32'd0);

      // Back-to-back frames with no idle gap, consumer acks each byte
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
         end
         begin
            consume(8'h00, "b2b byte0");
            consume(8'hFF, "b2b byte1");
         end
      join
      idle(2 * CPB);
      check("b2b overrun", 32'(ifc.overrun), 32'd0);

      // Vector table
      for (int v = 0; v < 4; v++) begin
         f0 = ferr_cnt;
         send_frame(vecs[v].tx, vecs[v].stop);
         idle(3 * CPB);
         check($sformatf("vec%0d data", v),      32'(ifc.data),       32'(vecs[v].exp_data));
         check($sformatf("vec%0d ready", v),     32'(ifc.data_ready), 32'(vecs[v].exp_ready));
         check($sformatf("vec%0d ferr", v),      32'(ferr_cnt - f0),  32'(vecs[v].exp_ferr));
         check($sformatf("vec%0d overrun", v),   32'(ifc.overrun),    32'(vecs[v].exp_ovr));
         check($sformatf("vec%0d busy", v),      32'(ifc.busy),       32'd0);
         if (vecs[v].ack) begin
            ifc.data_ack = 1'b1;
            idle(1);
            ifc.data_ack = 1'b0;
            check($sformatf("vec%0d acked", v), 32'(ifc.data_ready), 32'd0);
         end
      end

      // Reset in the middle of DATA for 8'h81 drops the partial byte
      RxD = 1'b0;
      idle(CPB);
      RxD = 1'b1;
      idle(CPB);
      RxD = 1'b0;
      idle(CPB / 2);
      check("abort busy before reset", 32'(ifc.busy), 32'd1);
      reset = 1'b1;
      RxD = 1'b1;
      idle(2);
      check("abort overrun cleared", 32'(ifc.overrun), 32'd0);
      reset = 1'b0;
      idle(3 * CPB);
      check("abort ready", 32'(ifc.data_ready), 32'd0);
      check("abort busy",  32'(ifc.busy),       32'd0);
      send_frame(8'h81, 1'b1);
      idle(CPB);
      check("refire data",  32'(ifc.data),       32'h81);
      check("refire ready", 32'(ifc.data_ready), 32'd1);

      // Ack on the exact completion cycle of a new byte: load wins, no overrun
      fork
         send_frame(8'h7E, 1'b1);
         begin
            idle(10 * CPB - 6);
            ifc.data_ack = 1'b1;
            idle(1);
            ifc.data_ack = 1'b0;
         end
      join
      idle(CPB);
      check("race data",    32'(ifc.data),       32'h7E);
      check("race ready",   32'(ifc.data_ready), 32'd1);
      check("race overrun", 32'(ifc.overrun),    32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
